// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_unit
// Description : ALU execution unit. Single-cycle logic/arithmetic, plus
//               WIDTH-cycle shift-add multiply and restoring divide.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       ALUInput,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             overflow,
    output logic             illegal,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [3:0] c_AND = 4'b0000;
    localparam logic [3:0] c_OR  = 4'b0001;
    localparam logic [3:0] c_ADD = 4'b0010;
    localparam logic [3:0] c_NOR = 4'b0011;
    localparam logic [3:0] c_XOR = 4'b0100;
    localparam logic [3:0] c_SUB = 4'b0110;
    localparam logic [3:0] c_SLT = 4'b0111;
    localparam logic [3:0] c_MUL = 4'b1010;
    localparam logic [3:0] c_DIV = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic                 zero_q, zero_d;
    logic                 ovf_q, ovf_d;
    logic                 ill_q, ill_d;

    logic                 w_accept;
    logic                 w_last;
    logic [WIDTH:0]       w_msum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH:0]       w_rtrial;
    logic                 w_rge;
    logic [WIDTH:0]       w_rnew;
    logic [2*WIDTH-1:0]   w_div_next;
    logic [WIDTH-1:0]     w_sum;
    logic [WIDTH-1:0]     w_diff;
    logic [WIDTH-1:0]     w_alu_res;
    logic                 w_alu_ovf;
    logic                 w_alu_ill;

    assign w_accept = start && (state_q == S_IDLE || state_q == S_DONE);
    assign w_last   = (cnt_q == CW'(WIDTH - 1));

    // Multiply: acc holds {partial high, remaining multiplier bits}.
    assign w_msum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign w_mul_next = {w_msum, acc_q[WIDTH-1:1]};

    // Divide: acc holds {partial remainder, dividend/quotient shift register}.
    assign w_rtrial   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign w_rge      = (w_rtrial >= {1'b0, opnd_q});
    assign w_rnew     = w_rge ? (w_rtrial - {1'b0, opnd_q}) : w_rtrial;
    assign w_div_next = {w_rnew[WIDTH-1:0], acc_q[WIDTH-2:0], w_rge};

    assign w_sum  = a + b;
    assign w_diff = a - b;

    always_comb begin
        w_alu_res = '0;
        w_alu_ovf = 1'b0;
        w_alu_ill = 1'b0;
        case (ALUInput)
            c_AND: w_alu_res = a & b;
            c_OR:  w_alu_res = a | b;
            c_NOR: w_alu_res = ~(a | b);
            c_XOR: w_alu_res = a ^ b;
            c_ADD: begin
                w_alu_res = w_sum;
                w_alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            c_SUB: begin
                w_alu_res = w_diff;
                w_alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            c_SLT: w_alu_res = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
            default: w_alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        result_d = result_q;
        hi_d     = hi_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        ill_d    = ill_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (w_accept) begin
                    cnt_d = '0;
                    if (ALUInput == c_MUL) begin
                        opnd_d  = a;
                        acc_d   = {{WIDTH{1'b0}}, b};
                        state_d = S_MUL;
                    end else if (ALUInput == c_DIV && b != '0) begin
                        opnd_d  = b;
                        acc_d   = {{WIDTH{1'b0}}, a};
                        state_d = S_DIV;
                    end else if (ALUInput == c_DIV) begin
                        result_d = '1;
                        hi_d     = a;
                        zero_d   = 1'b0;
                        ovf_d    = 1'b0;
                        ill_d    = 1'b0;
                        state_d  = S_DONE;
                    end else begin
                        result_d = w_alu_res;
                        hi_d     = '0;
                        zero_d   = (w_alu_res == '0);
                        ovf_d    = w_alu_ovf;
                        ill_d    = w_alu_ill;
                        state_d  = S_DONE;
                    end
                end
            end
            S_MUL, S_DIV: begin
                acc_d = (state_q == S_MUL) ? w_mul_next : w_div_next;
                cnt_d = cnt_q + CW'(1);
                if (w_last) begin
                    result_d = acc_d[WIDTH-1:0];
                    hi_d     = acc_d[2*WIDTH-1:WIDTH];
                    zero_d   = (acc_d[WIDTH-1:0] == '0);
                    ovf_d    = 1'b0;
                    ill_d    = 1'b0;
                    state_d  = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            result_q <= '0;
            hi_q     <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            ill_q    <= ill_d;
        end
    end

    assign result   = result_q;
    assign hi       = hi_q;
    assign zero     = zero_q;
    assign overflow = ovf_q;
    assign illegal  = ill_q;
    assign busy     = (state_q == S_MUL) || (state_q == S_DIV);
    assign done     = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_exec_unit
// Description : Self-checking bench for alu_exec_unit against an arithmetic
//               reference model; directed cases followed by random operations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

    localparam longint c_MAXS = 64'sd2147483647;
    localparam longint c_MINS = -64'sd2147483648;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [3:0]  ALUInput;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic [31:0] hi;
    logic        zero;
    logic        overflow;
    logic        illegal;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .ALUInput (ALUInput),
        .a        (a),
        .b        (b),
        .result   (result),
        .hi       (hi),
        .zero     (zero),
        .overflow (overflow),
        .illegal  (illegal),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic [31:0] h,
                                  output logic o, output logic il, output logic z,
                                  output int lat);
        longint      sx;
        longint      sy;
        longint      t;
        logic [63:0] p;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        r   = '0;
        h   = '0;
        o   = 1'b0;
        il  = 1'b0;
        lat = 1;
        case (c)
            4'd0:  r = x & y;
            4'd1:  r = x | y;
            4'd2:  begin t = sx + sy; r = t[31:0]; o = (t > c_MAXS) || (t < c_MINS); end
            4'd6:  begin t = sx - sy; r = t[31:0]; o = (t > c_MAXS) || (t < c_MINS); end
            4'd7:  r = (sx < sy) ? 32'd1 : 32'd0;
            4'd3:  r = ~(x | y);
            4'd4:  r = x ^ y;
            4'd10: begin p = 64'(x) * 64'(y); r = p[31:0]; h = p[63:32]; lat = 33; end
            4'd15: begin
                if (y == 0) begin r = '1; h = x; end
                else begin r = x / y; h = x % y; lat = 33; end
            end
            default: il = 1'b1;
        endcase
        z = (r == 0);
    endfunction

    // Called at a falling edge; returns at the falling edge of the done cycle.
    task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] x,
                          input logic [31:0] y, input bit gap, input bit spam);
        logic [31:0] er, eh;
        logic        eo, ei, ez;
        int          lat;
        int          k;
        bit          seen;
        if (gap) begin
            @(negedge clk);
            chk({tag, ".idle_done"}, 32'(done), 32'd0);
        end
        model(c, x, y, er, eh, eo, ei, ez, lat);
        start    = 1'b1;
        ALUInput = c;
        a        = x;
        b        = y;
        k        = 0;
        seen     = 1'b0;
        while (k < 100 && !seen) begin
            @(negedge clk);
            k++;
            if (!spam) start = 1'b0;
            if (done) begin
                seen  = 1'b1;
                start = 1'b0;
            end else begin
                chk({tag, ".busy"}, 32'(busy), 32'd1);
                if (spam) begin
                    start    = 1'($urandom_range(0, 1));
                    ALUInput = 4'($urandom);
                    a        = $urandom;
                    b        = $urandom;
                end
            end
        end
        chk({tag, ".latency"}, 32'(k), 32'(lat));
        chk({tag, ".busy_at_done"}, 32'(busy), 32'd0);
        chk({tag, ".result"}, result, er);
        chk({tag, ".hi"}, hi, eh);
        chk({tag, ".zero"}, 32'(zero), 32'(ez));
        chk({tag, ".overflow"}, 32'(overflow), 32'(eo));
        chk({tag, ".illegal"}, 32'(illegal), 32'(ei));
    endtask

    logic [3:0] codes [10] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd3, 4'd4, 4'd10, 4'd15, 4'd9};

    initial begin
        logic [3:0]  rc;
        logic [31:0] ra, rb;
        reset_n  = 1'b0;
        start    = 1'b0;
        ALUInput = '0;
        a        = '0;
        b        = '0;
        #2;
        chk("reset.result", result, 32'd0);
        chk("reset.hi", hi, 32'd0);
        chk("reset.flags", {27'd0, zero, overflow, illegal, busy, done}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        run_op("add_ovf", 4'd2, 32'h7FFFFFFF, 32'd1, 1'b1, 1'b0);
        run_op("sub_zero", 4'd6, 32'd5, 32'd5, 1'b1, 1'b0);
        run_op("slt_neg", 4'd7, 32'hFFFFFFFF, 32'd1, 1'b1, 1'b0);
        run_op("nor_zero", 4'd3, 32'd0, 32'd0, 1'b1, 1'b0);
        run_op("xor", 4'd4, 32'hF0F0F0F0, 32'hFFFF0000, 1'b1, 1'b0);
        run_op("mul_spam", 4'd10, 32'hFFFFFFFF, 32'd2, 1'b1, 1'b1);
        run_op("div", 4'd15, 32'd100, 32'd7, 1'b1, 1'b0);
        run_op("div_by0", 4'd15, 32'd9, 32'd0, 1'b1, 1'b0);
        run_op("illegal", 4'd9, 32'h1234, 32'h5678, 1'b1, 1'b0);
        run_op("b2b_add", 4'd2, 32'd2, 32'd3, 1'b0, 1'b0);
        run_op("sub_ovf", 4'd6, 32'h80000000, 32'd1, 1'b0, 1'b0);
        run_op("mul_pre", 4'd10, 32'h00012345, 32'h00067890, 1'b1, 1'b0);

        // Abort a multiply partway through with an asynchronous reset.
        @(negedge clk);
        start    = 1'b1;
        ALUInput = 4'd10;
        a        = 32'hDEADBEEF;
        b        = 32'h12345678;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("abort.busy_before", 32'(busy), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort.result", result, 32'd0);
        chk("abort.hi", hi, 32'd0);
        chk("abort.flags", {27'd0, zero, overflow, illegal, busy, done}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("abort.no_done", {30'd0, busy, done}, 32'd0);
        end
        reset_n = 1'b1;
        run_op("add_after_reset", 4'd2, 32'd40, 32'd2, 1'b1, 1'b0);

        for (int i = 0; i < 24; i++) begin
            rc = codes[$urandom_range(0, 9)];
            ra = $urandom;
            rb = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
            run_op($sformatf("rand%0d", i), rc, ra, rb, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        chk("final.done_low", 32'(done), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
